// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // Enable/flush bundle driven onto the pipeline registers.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_PASS      = ctrl_t'(8'b11111_000);
    localparam ctrl_t CTRL_BRANCH    = ctrl_t'(8'b11111_100);
    localparam ctrl_t CTRL_LOAD_USE  = ctrl_t'(8'b00111_010);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(8'b00001_001);
    localparam ctrl_t CTRL_HOLD      = ctrl_t'(8'b00000_000);
    localparam ctrl_t CTRL_RESET     = ctrl_t'(8'b00000_111);

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational load-use hazard comparator between the EX load and the ID sources.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_wn,
    output logic             hazard
);

    logic w_rs_match;
    logic w_rt_match;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign w_rs_match = (ex_wn == id_rs);
    assign w_rt_match = id_uses_rt && (ex_wn == id_rt);
    assign hazard     = ex_mem_read && (ex_wn != '0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: memory freeze, load-use bubble, branch flush, timeout.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_wn,
    input  logic             br_taken,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t              r_state;
    state_t              w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_acc;
    logic                w_hazard;
    logic                w_req;
    logic                w_err;
    ctrl_t               w_release_ctrl;
    ctrl_t               w_ctrl;

    assign w_acc = mem_rd || mem_wr;

    hazard_detect u_hazard (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_wn       (ex_wn),
        .hazard      (w_hazard)
    );

    // Controls when memory is not stalling: load-use bubble beats branch flush.
    assign w_release_ctrl = w_hazard ? CTRL_LOAD_USE :
                            br_taken ? CTRL_BRANCH   : CTRL_PASS;

    // Next state, wait counter and Mealy control outputs.
    always_comb begin
        w_next_state = r_state;
        w_wait_nxt   = r_wait_cnt;
        w_ctrl       = CTRL_PASS;
        w_req        = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            RUN: begin
                w_req = w_acc;
                if (w_acc && !dmem_ready) begin
                    w_ctrl       = CTRL_MEM_STALL;
                    w_next_state = MEM_WAIT;
                    // The entering RUN cycle already counts as the first not-ready cycle.
                    w_wait_nxt   = WAIT_W'(1);
                end else begin
                    w_ctrl     = w_release_ctrl;
                    w_wait_nxt = '0;
                end
            end
            MEM_WAIT: begin
                w_req = w_acc;
                if (!dmem_ready) begin
                    w_ctrl = CTRL_MEM_STALL;
                    if (r_wait_cnt >= WAIT_W'(MAX_WAIT)) begin
                        w_next_state = ERR;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // Stall releases; hazard and branch are re-evaluated this cycle.
                    w_ctrl       = w_release_ctrl;
                    w_next_state = RUN;
                    w_wait_nxt   = '0;
                end
            end
            ERR: begin
                w_ctrl = CTRL_HOLD;
                w_err  = 1'b1;
            end
            default: begin
                w_ctrl       = CTRL_HOLD;
                w_next_state = RUN;
                w_wait_nxt   = '0;
            end
        endcase
        // Hold the pipe clear for as long as reset is asserted.
        if (!rst_n) begin
            w_ctrl = CTRL_RESET;
            w_req  = 1'b0;
            w_err  = 1'b0;
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!w_ctrl.pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign dmem_req    = w_req;
    assign err         = w_err;
    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign idex_en     = w_ctrl.idex_en;
    assign exmem_en    = w_ctrl.exmem_en;
    assign memwb_en    = w_ctrl.memwb_en;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign memwb_flush = w_ctrl.memwb_flush;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_pipe_ctrl;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int          SAT      = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_wn;
    logic             id_uses_rt, ex_mem_read, br_taken;
    logic             mem_rd, mem_wr, dmem_ready;
    logic             dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, memwb_flush, err;
    logic [CNT_W-1:0] stall_cnt;

    pipe_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_wn       (ex_wn),
        .br_taken    (br_taken),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .dmem_ready  (dmem_ready),
        .dmem_req    (dmem_req),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .memwb_flush (memwb_flush),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    // Reference model: consecutive not-ready cycles of the pending access, error flag, stall count.
    int    m_nr    = 0;
    bit    m_err   = 1'b0;
    int    m_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s t=%0t got=%h expected=%h", phase, tag, $time, got, exp);
        end
    endtask

    // One cycle: settle, compare against the model, clock, advance the model.
    task automatic tick();
        logic       acc, haz, stall, rst_seen;
        logic [9:0] e, g;
        #4;
        rst_seen = rst_n;
        stall    = 1'b0;
        if (!rst_n) begin
            m_nr = 0; m_err = 1'b0; m_stall = 0;
            e = 10'b0_00000_111_0;
        end else if (m_err) begin
            e = 10'b0_00000_000_1;
        end else begin
            acc   = mem_rd | mem_wr;
            haz   = ex_mem_read && (ex_wn != 5'd0) &&
                    ((ex_wn == id_rs) || (id_uses_rt && (ex_wn == id_rt)));
            stall = (m_nr > 0) ? !dmem_ready : (acc && !dmem_ready);
            if (stall)         e = {acc, 5'b00001, 3'b001, 1'b0};
            else if (haz)      e = {acc, 5'b00111, 3'b010, 1'b0};
            else if (br_taken) e = {acc, 5'b11111, 3'b100, 1'b0};
            else               e = {acc, 5'b11111, 3'b000, 1'b0};
        end
        g = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, memwb_flush, err};
        check("ctrl", 32'(g), 32'(e));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        @(posedge clk);
        #1;
        if (rst_seen) begin
            if (!e[8] && m_stall < SAT) m_stall++;
            if (!m_err) begin
                if (stall) begin
                    m_nr++;
                    if (m_nr == MAX_WAIT + 1) m_err = 1'b1;
                end else begin
                    m_nr = 0;
                end
            end
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_wn = 5'd0; br_taken = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        phase = "reset";
        tick(); tick();
        rst_n = 1'b1;
        phase = "idle";
        tick(); tick();

        phase = "load_use_rs";
        ex_mem_read = 1'b1; ex_wn = 5'd8; id_rs = 5'd8;
        tick();
        ex_mem_read = 1'b0;
        tick();

        phase = "load_use_rt";
        ex_mem_read = 1'b1; ex_wn = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        tick();
        id_uses_rt = 1'b0;
        tick();
        idle_inputs();

        phase = "branch";
        br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        tick();

        phase = "wn_zero";
        ex_mem_read = 1'b1; ex_wn = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        tick();
        idle_inputs();

        phase = "zero_wait";
        mem_rd = 1'b1; dmem_ready = 1'b1;
        tick();
        idle_inputs();

        phase = "mem_wait3";
        mem_rd = 1'b1; dmem_ready = 1'b0;
        repeat (3) tick();
        dmem_ready = 1'b1;
        tick();
        idle_inputs();
        tick();

        phase = "combo";
        mem_wr = 1'b1; ex_mem_read = 1'b1; ex_wn = 5'd8; id_rs = 5'd8; br_taken = 1'b1;
        repeat (2) tick();
        dmem_ready = 1'b1;
        tick();
        mem_wr = 1'b0; ex_mem_read = 1'b0;
        tick();
        idle_inputs();
        tick();

        phase = "reset_mid_wait";
        mem_rd = 1'b1; dmem_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        dmem_ready = 1'b1;
        tick();
        idle_inputs();

        phase = "timeout";
        mem_rd = 1'b1; dmem_ready = 1'b0;
        repeat (8) tick();
        mem_rd = 1'b0; dmem_ready = 1'b1; br_taken = 1'b1;
        repeat (3) tick();
        idle_inputs();

        phase = "saturate";
        repeat (SAT + 5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        phase = "random";
        repeat (3000) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            id_rs       = 5'($urandom_range(0, 7));
            id_rt       = 5'($urandom_range(0, 7));
            ex_wn       = 5'($urandom_range(0, 7));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            br_taken    = ($urandom_range(0, 3) == 0);
            mem_rd      = ($urandom_range(0, 3) == 0);
            mem_wr      = ($urandom_range(0, 7) == 0);
            dmem_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
